// File: rtl/vga_sortie_pkg.sv
// vga_pkg: default 640x480@60 timing constants and the coordinate type
// shared by the VGA output stage (vga_sortie) and its counters.
package vga_pkg;

   localparam int unsigned COORD_W = 10;

   localparam int unsigned H_VIS_D  = 640;
   localparam int unsigned H_FP_D   = 16;
   localparam int unsigned H_SYNC_D = 96;
   localparam int unsigned H_BP_D   = 48;

   localparam int unsigned V_VIS_D  = 480;
   localparam int unsigned V_FP_D   = 10;
   localparam int unsigned V_SYNC_D = 2;
   localparam int unsigned V_BP_D   = 33;

   localparam int unsigned H_TOT = H_VIS_D + H_FP_D + H_SYNC_D + H_BP_D;
   localparam int unsigned V_TOT = V_VIS_D + V_FP_D + V_SYNC_D + V_BP_D;

   typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_sortie_compteur.sv
// compteur_mod: modulo-N counter with enable; o_wrap flags the terminal
// count N-1 so the caller can chain a second counter or detect frame end.
module compteur_mod
   import vga_pkg::*;
#(
   parameter int unsigned N = H_TOT
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_en,
   output coord_t o_cpt,
   output logic   o_wrap
);

   coord_t r_cpt;

   assign o_wrap = (r_cpt == coord_t'(N - 1));
   assign o_cpt  = r_cpt;

   // Advance on enable, returning to 0 after N-1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cpt <= '0;
      else if (i_en)
         r_cpt <= o_wrap ? '0 : r_cpt + 1'b1;
   end

endmodule

// File: rtl/vga_sortie.sv
// vga_sortie: VGA timing generator and registered colour output stage.
// A 25 MHz pixel enable is derived from the 50 MHz clock; colour and syncs
// are registered one pixel after the coordinates are presented on x_o/y_o.
// Optional feature: define VGA_MIRE_EN to add input mire_i, which replaces
// the colour inputs by 8 vertical colour bars.
module vga_sortie
   import vga_pkg::*;
#(
   parameter int unsigned H_VIS  = H_VIS_D,
   parameter int unsigned H_FP   = H_FP_D,
   parameter int unsigned H_SYNC = H_SYNC_D,
   parameter int unsigned H_BP   = H_BP_D,
   parameter int unsigned V_VIS  = V_VIS_D,
   parameter int unsigned V_FP   = V_FP_D,
   parameter int unsigned V_SYNC = V_SYNC_D,
   parameter int unsigned V_BP   = V_BP_D
) (
   input  logic       clk,
   input  logic       rst_n,
`ifdef VGA_MIRE_EN
   input  logic       mire_i,
`endif
   input  logic [2:0] rouge_i,
   input  logic [2:0] vert_i,
   input  logic [1:0] bleu_i,
   output logic [9:0] x_o,
   output logic [9:0] y_o,
   output logic       actif_o,
   output logic       trame_o,
   output logic [2:0] rouge_o,
   output logic [2:0] vert_o,
   output logic [1:0] bleu_o,
   output logic       hsync_n,
   output logic       vsync_n
);

   localparam int unsigned LP_H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned LP_V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int unsigned LP_HS_DEB = H_VIS + H_FP;
   localparam int unsigned LP_HS_FIN = H_VIS + H_FP + H_SYNC;
   localparam int unsigned LP_VS_DEB = V_VIS + V_FP;
   localparam int unsigned LP_VS_FIN = V_VIS + V_FP + V_SYNC;

   logic       r_pix_en;
   coord_t     w_hcpt;
   coord_t     w_vcpt;
   logic       w_hwrap;
   logic       w_vwrap;
   logic       w_actif;
   logic       w_hsync_n;
   logic       w_vsync_n;
   logic [2:0] w_rouge;
   logic [2:0] w_vert;
   logic [1:0] w_bleu;
   logic [2:0] r_rouge;
   logic [2:0] r_vert;
   logic [1:0] r_bleu;
   logic       r_hsync_n;
   logic       r_vsync_n;
   logic       r_trame;

   // Pixel enable: high on every other clk, first high edge is the second after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_pix_en <= 1'b0;
      else
         r_pix_en <= ~r_pix_en;
   end

   compteur_mod #(.N(LP_H_TOT)) u_hcpt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (r_pix_en),
      .o_cpt  (w_hcpt),
      .o_wrap (w_hwrap)
   );

   compteur_mod #(.N(LP_V_TOT)) u_vcpt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (r_pix_en & w_hwrap),
      .o_cpt  (w_vcpt),
      .o_wrap (w_vwrap)
   );

   assign w_actif   = (w_hcpt < coord_t'(H_VIS)) && (w_vcpt < coord_t'(V_VIS));
   assign w_hsync_n = !((w_hcpt >= coord_t'(LP_HS_DEB)) && (w_hcpt < coord_t'(LP_HS_FIN)));
   assign w_vsync_n = !((w_vcpt >= coord_t'(LP_VS_DEB)) && (w_vcpt < coord_t'(LP_VS_FIN)));

`ifdef VGA_MIRE_EN
   localparam int unsigned LP_BANDE = H_VIS / 8;
   logic [2:0] w_bande;
   assign w_bande = 3'(w_hcpt / coord_t'(LP_BANDE));
`endif

   // Colour source: mapper inputs, or the bar pattern when enabled
   always_comb begin
      w_rouge = rouge_i;
      w_vert  = vert_i;
      w_bleu  = bleu_i;
`ifdef VGA_MIRE_EN
      if (mire_i) begin
         w_rouge = {3{w_bande[2]}};
         w_vert  = {3{w_bande[1]}};
         w_bleu  = {2{w_bande[0]}};
      end
`endif
   end

   // Output pipeline: colour/syncs on pixel edges, frame pulse lasts one clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rouge   <= '0;
         r_vert    <= '0;
         r_bleu    <= '0;
         r_hsync_n <= 1'b1;
         r_vsync_n <= 1'b1;
         r_trame   <= 1'b0;
      end else begin
         r_trame <= r_pix_en & w_hwrap & w_vwrap;
         if (r_pix_en) begin
            r_rouge   <= w_actif ? w_rouge : '0;
            r_vert    <= w_actif ? w_vert  : '0;
            r_bleu    <= w_actif ? w_bleu  : '0;
            r_hsync_n <= w_hsync_n;
            r_vsync_n <= w_vsync_n;
         end
      end
   end

   assign x_o     = w_hcpt;
   assign y_o     = w_vcpt;
   assign actif_o = w_actif;
   assign trame_o = r_trame;
   assign rouge_o = r_rouge;
   assign vert_o  = r_vert;
   assign bleu_o  = r_bleu;
   assign hsync_n = r_hsync_n;
   assign vsync_n = r_vsync_n;

endmodule

// File: tb/tb_vga_sortie.sv
// tb_vga_sortie: random colour stimulus against an arithmetic pixel model.
// Two instances: default timing (line-level behaviour) and a reduced timing
// so whole frames and a mid-frame reset fit in a short run.
module tb_vga_sortie;

   // Reduced timing for the small instance
   localparam int unsigned S_HV = 40, S_HFP = 4, S_HS = 8, S_HBP = 6;
   localparam int unsigned S_VV = 20, S_VFP = 2, S_VS = 2, S_VBP = 3;
   localparam int unsigned S_HT = S_HV + S_HFP + S_HS + S_HBP;
   localparam int unsigned S_VT = S_VV + S_VFP + S_VS + S_VBP;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       actif;
      logic       trame;
      logic       hs_n;
      logic       vs_n;
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       r_mire = 1'b0;
   logic [2:0] r_rouge = '0;
   logic [2:0] r_vert = '0;
   logic [1:0] r_bleu = '0;

   logic [9:0] d_x, d_y, s_x, s_y;
   logic       d_actif, d_trame, d_hs, d_vs, s_actif, s_trame, s_hs, s_vs;
   logic [2:0] d_r, d_g, s_r, s_g;
   logic [1:0] d_b, s_b;

   int unsigned n_verif = 0;
   int unsigned n_echec = 0;
   bit          chk_on = 1'b0;

   longint unsigned edge_cnt = 0;
   longint unsigned n_pix = 0;
   logic [8:0]      s_col = '0;

   always #10 clk = ~clk;

   vga_sortie dut (
      .clk(clk), .rst_n(rst_n),
`ifdef VGA_MIRE_EN
      .mire_i(r_mire),
`endif
      .rouge_i(r_rouge), .vert_i(r_vert), .bleu_i(r_bleu),
      .x_o(d_x), .y_o(d_y), .actif_o(d_actif), .trame_o(d_trame),
      .rouge_o(d_r), .vert_o(d_g), .bleu_o(d_b),
      .hsync_n(d_hs), .vsync_n(d_vs)
   );

   vga_sortie #(
      .H_VIS(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
      .V_VIS(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
   ) dut_s (
      .clk(clk), .rst_n(rst_n),
`ifdef VGA_MIRE_EN
      .mire_i(r_mire),
`endif
      .rouge_i(r_rouge), .vert_i(r_vert), .bleu_i(r_bleu),
      .x_o(s_x), .y_o(s_y), .actif_o(s_actif), .trame_o(s_trame),
      .rouge_o(s_r), .vert_o(s_g), .bleu_o(s_b),
      .hsync_n(s_hs), .vsync_n(s_vs)
   );

   task automatic verif(input string tag, input longint unsigned obs, input longint unsigned exp);
      n_verif++;
      if (obs != exp) begin
         n_echec++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected outputs after n pixel steps; colour c = {mire, r, g, b} sampled at step n
   function automatic obs_t modele(input int unsigned hv, hfp, hs, hbp, vv, vfp, vs, vbp,
                                   input longint unsigned n, input logic pair, input logic [8:0] c);
      longint unsigned ht, vt, pp, ph, pv, k;
      obs_t e;
      ht = hv + hfp + hs + hbp;
      vt = vv + vfp + vs + vbp;
      e = '0;
      e.x     = 10'(n % ht);
      e.y     = 10'((n / ht) % vt);
      e.actif = ((n % ht) < hv) && (((n / ht) % vt) < vv);
      e.hs_n  = 1'b1;
      e.vs_n  = 1'b1;
      if (n > 0) begin
         pp = n - 1;
         ph = pp % ht;
         pv = (pp / ht) % vt;
         if (ph < hv && pv < vv) begin
            if (c[8]) begin
               k = ph / (hv / 8);
               e.r = {3{k[2]}};
               e.g = {3{k[1]}};
               e.b = {2{k[0]}};
            end else begin
               {e.r, e.g, e.b} = c[7:0];
            end
         end
         e.hs_n  = !(ph >= hv + hfp && ph < hv + hfp + hs);
         e.vs_n  = !(pv >= vv + vfp && pv < vv + vfp + vs);
         e.trame = pair && (n % (ht * vt) == 0);
      end
      return e;
   endfunction

   task automatic comparer(input string p, input obs_t o, input obs_t e);
      verif({p, "x"}, o.x, e.x);
      verif({p, "y"}, o.y, e.y);
      verif({p, "actif"}, o.actif, e.actif);
      verif({p, "trame"}, o.trame, e.trame);
      verif({p, "hsync_n"}, o.hs_n, e.hs_n);
      verif({p, "vsync_n"}, o.vs_n, e.vs_n);
      verif({p, "rouge"}, o.r, e.r);
      verif({p, "vert"}, o.g, e.g);
      verif({p, "bleu"}, o.b, e.b);
   endtask

   // Reference time base: clk edges since reset release, pixel steps on even edges
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt = 0;
         n_pix    = 0;
      end else begin
         edge_cnt++;
         if (edge_cnt % 2 == 0) begin
            n_pix++;
            s_col = {r_mire, r_rouge, r_vert, r_bleu};
         end
      end
   end

   // New random colour every clk (also between pixel edges)
   always @(negedge clk) begin
      {r_rouge, r_vert, r_bleu} = 8'($urandom);
`ifdef VGA_MIRE_EN
      r_mire = 1'($urandom_range(0, 1));
`endif
   end

   // Per-clk comparison of both instances against the model
   always @(negedge clk) begin
      if (chk_on) begin
         logic pair;
         pair = (edge_cnt > 0) && (edge_cnt % 2 == 0);
         comparer("d.", {d_x, d_y, d_actif, d_trame, d_hs, d_vs, d_r, d_g, d_b},
                  modele(640, 16, 96, 48, 480, 10, 2, 33, n_pix, pair, s_col));
         comparer("s.", {s_x, s_y, s_actif, s_trame, s_hs, s_vs, s_r, s_g, s_b},
                  modele(S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP, n_pix, pair, s_col));
      end
   end

   initial begin
      int unsigned nb_trame, nb_hs_bas, nb_vs_bas;
      bit trouve;
      #1 chk_on = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // First 3200 clk: one full small frame plus two default lines
      nb_trame = 0; nb_hs_bas = 0; nb_vs_bas = 0;
      for (int i = 0; i < 3200; i++) begin
         @(negedge clk);
         if (s_trame) nb_trame++;
         if (!s_hs) nb_hs_bas++;
         if (!s_vs) nb_vs_bas++;
         if (i == 1599) begin
            verif("ligne_x", d_x, 0);
            verif("ligne_y", d_y, 1);
         end
      end
      verif("nb_trame", nb_trame, 1);
      verif("nb_hsync_bas", nb_hs_bas, 2 * S_HS * S_VT);
      verif("nb_vsync_bas", nb_vs_bas, 2 * S_VS * S_HT);

      // Mid-frame reset while the small instance is inside its hsync pulse
      trouve = 1'b0;
      for (int i = 0; i < 8000 && !trouve; i++) begin
         @(negedge clk);
         if (n_pix % S_HT == S_HV + S_HFP + 2 && (n_pix / S_HT) % S_VT == 10) trouve = 1'b1;
      end
      verif("attente_position", trouve, 1);
      verif("hsync_avant_reset", s_hs, 0);
      #5 rst_n = 1'b0;
      #1;
      verif("rst_hsync", s_hs, 1);
      verif("rst_vsync", s_vs, 1);
      verif("rst_couleur", {s_r, s_g, s_b}, 0);
      verif("rst_xy", {s_x, s_y}, 0);
      verif("rst_trame", s_trame, 0);
      verif("rst_d_xy", {d_x, d_y}, 0);
      verif("rst_d_couleur", {d_r, d_g, d_b}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (1700) @(negedge clk);

      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_verif, n_echec);
      $finish;
   end

endmodule
